calendar_ctrl: RTL and testbench

Parametrised date keeper for the board clock/calendar application: holds year/month/day/weekday, advances them automatically on a day-rollover pulse from the timekeeping block, and lets the user edit each field through the shared set/up/down buttons. Adds leap-year February, day clamping on month/year edits, edge-detected set, auto-repeat on held up/down, and blinking of the field under edit. Drives six 7-segment digits (YY MM DD) and the six weekday LEDs.

---
 rtl/calendar_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_calendar_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/calendar_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calendar_ctrl
// Purpose  : Year/month/day/weekday keeper with button editing, auto-repeat,
//            blinking of the edited field and 7-segment/LED output drive.
// Revision : 1.0
// ============================================================================
module calendar_ctrl #(
    parameter int REPEAT_DIV = 40000,
    parameter int BLINK_DIV  = 500000,
    parameter int ACTIVE_ID  = 1,
    parameter int LEAP_EN    = 1
) (
    input  logic       clkBoard,
    input  logic       reset,
    input  logic [2:0] isUsing,
    input  logic       set,
    input  logic       up,
    input  logic       down,
    input  logic       day_tick,
    output logic [6:0] d1,
    output logic [6:0] d2,
    output logic [6:0] d3,
    output logic [6:0] d4,
    output logic [6:0] d5,
    output logic [6:0] d6,
    output logic [5:0] led,
    output logic [2:0] edit_state
);
    typedef enum logic [2:0] {
        ST_DISP  = 3'd0,
        ST_YEAR  = 3'd1,
        ST_MONTH = 3'd2,
        ST_DAY   = 3'd3,
        ST_WDAY  = 3'd4
    } state_t;

    localparam int RPT_W = $clog2(REPEAT_DIV + 1);
    localparam int BLK_W = $clog2(BLINK_DIV + 1);

    state_t           state_q, state_d;
    logic [6:0]       year_q, year_d;
    logic [3:0]       month_q, month_d;
    logic [4:0]       day_q, day_d;
    logic [2:0]       wday_q, wday_d;
    logic             set_q, up_q, down_q;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             phase_q, phase_d;

    function automatic logic [4:0] dim(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd2:                      dim = (LEAP_EN != 0 && y[1:0] == 2'd0) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:  dim = 5'd30;
            default:                   dim = 5'd31;
        endcase
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            default: seg = 7'b1111011;
        endcase
    endfunction

    function automatic logic [13:0] two_dig(input logic [6:0] v);
        two_dig = {seg(4'(v / 7'd10)), seg(4'(v % 7'd10))};
    endfunction

    logic w_in_use, w_set_rise, w_dir_up, w_dir_dn, w_rise, w_rpt_hit, w_step, w_blk_hit;
    logic [4:0] w_dim_cur;

    assign w_in_use   = (isUsing == 3'(ACTIVE_ID));
    assign w_set_rise = w_in_use & set & ~set_q;
    assign w_dir_up   = w_in_use & up & ~down;
    assign w_dir_dn   = w_in_use & down & ~up;
    assign w_rise     = (up & ~up_q) | (down & ~down_q);
    assign w_rpt_hit  = (rpt_q == RPT_W'(REPEAT_DIV - 1));
    assign w_step     = (w_dir_up | w_dir_dn) & (w_rise | w_rpt_hit);
    assign w_blk_hit  = (blk_q == BLK_W'(BLINK_DIV - 1));
    assign w_dim_cur  = dim(month_q, year_q);

    always_comb begin
        state_d = state_q;
        year_d  = year_q;
        month_d = month_q;
        day_d   = day_q;
        wday_d  = wday_q;
        rpt_d   = '0;
        blk_d   = w_blk_hit ? '0 : blk_q + 1'b1;
        phase_d = w_blk_hit ? ~phase_q : phase_q;

        if ((w_dir_up | w_dir_dn) && !(w_rise || w_rpt_hit))
            rpt_d = rpt_q + 1'b1;

        if (state_q == ST_DISP && day_tick) begin
            wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
            if (day_q >= w_dim_cur) begin
                day_d = 5'd1;
                if (month_q == 4'd12) begin
                    month_d = 4'd1;
                    year_d  = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                end else begin
                    month_d = month_q + 4'd1;
                end
            end else begin
                day_d = day_q + 5'd1;
            end
        end

        if (w_step) begin
            case (state_q)
                ST_YEAR: begin
                    if (w_dir_up) year_d = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                    else          year_d = (year_q == 7'd0) ? 7'd99 : year_q - 7'd1;
                    if (day_q > dim(month_q, year_d)) day_d = dim(month_q, year_d);
                end
                ST_MONTH: begin
                    if (w_dir_up) month_d = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
                    else          month_d = (month_q == 4'd1) ? 4'd12 : month_q - 4'd1;
                    if (day_q > dim(month_d, year_q)) day_d = dim(month_d, year_q);
                end
                ST_DAY: begin
                    if (w_dir_up) day_d = (day_q >= w_dim_cur) ? 5'd1 : day_q + 5'd1;
                    else          day_d = (day_q == 5'd1) ? w_dim_cur : day_q - 5'd1;
                end
                ST_WDAY: begin
                    if (w_dir_up) wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
                    else          wday_d = (wday_q == 3'd0) ? 3'd6 : wday_q - 3'd1;
                end
                default: ;
            endcase
        end

        if (w_set_rise) begin
            case (state_q)
                ST_DISP:  state_d = ST_YEAR;
                ST_YEAR:  state_d = ST_MONTH;
                ST_MONTH: state_d = ST_DAY;
                ST_DAY:   state_d = ST_WDAY;
                default:  state_d = ST_DISP;
            endcase
        end
    end

    // Display image from the current fields; blanking hides only the edited field.
    logic [13:0] w_yy, w_mm, w_dd;
    logic [5:0]  w_led;
    logic        w_blank;

    assign w_blank = ~phase_q;

    always_comb begin
        w_yy = two_dig(year_q);
        w_mm = two_dig({3'b000, month_q});
        w_dd = two_dig({2'b00, day_q});
        case (wday_q)
            3'd0:    w_led = 6'b111111;
            3'd1:    w_led = 6'b100000;
            3'd2:    w_led = 6'b010000;
            3'd3:    w_led = 6'b001000;
            3'd4:    w_led = 6'b000100;
            3'd5:    w_led = 6'b000010;
            default: w_led = 6'b000001;
        endcase
        if (w_blank) begin
            case (state_q)
                ST_YEAR:  w_yy  = '0;
                ST_MONTH: w_mm  = '0;
                ST_DAY:   w_dd  = '0;
                ST_WDAY:  w_led = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkBoard) begin
        if (reset) begin
            state_q    <= ST_DISP;
            year_q     <= 7'd0;
            month_q    <= 4'd1;
            day_q      <= 5'd1;
            wday_q     <= 3'd0;
            set_q      <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            rpt_q      <= '0;
            blk_q      <= '0;
            phase_q    <= 1'b1;
            d1         <= 7'b1111110;
            d2         <= 7'b1111110;
            d3         <= 7'b1111110;
            d4         <= 7'b0110000;
            d5         <= 7'b1111110;
            d6         <= 7'b0110000;
            led        <= 6'b111111;
            edit_state <= 3'd0;
        end else begin
            state_q    <= state_d;
            year_q     <= year_d;
            month_q    <= month_d;
            day_q      <= day_d;
            wday_q     <= wday_d;
            set_q      <= set;
            up_q       <= up;
            down_q     <= down;
            rpt_q      <= rpt_d;
            blk_q      <= blk_d;
            phase_q    <= phase_d;
            {d1, d2}   <= w_yy;
            {d3, d4}   <= w_mm;
            {d5, d6}   <= w_dd;
            led        <= w_led;
            edit_state <= state_q;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_calendar_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_calendar_ctrl
// Purpose  : Directed scoreboard bench for calendar_ctrl.
// Revision : 1.0
// ============================================================================
module tb_calendar_ctrl;
    localparam int R = 4;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] isUsing = 3'd1;
    logic       set = 1'b0, up = 1'b0, down = 1'b0, day_tick = 1'b0;
    logic [6:0] d1, d2, d3, d4, d5, d6;
    logic [5:0] led;
    logic [2:0] edit_state;

    always #5 clk = ~clk;

    calendar_ctrl #(.REPEAT_DIV(R), .BLINK_DIV(B), .ACTIVE_ID(1), .LEAP_EN(1)) dut (
        .clkBoard(clk), .reset(reset), .isUsing(isUsing), .set(set), .up(up),
        .down(down), .day_tick(day_tick), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .d5(d5), .d6(d6), .led(led), .edit_state(edit_state)
    );

    typedef struct {
        string       name;
        int          kind;
        logic [50:0] exp;
        logic [50:0] mask;
        int          act;
    } item_t;

    item_t q[$];
    item_t it;
    int n_chk = 0;
    int n_pass = 0;
    logic [50:0] obs;
    assign obs = {d1, d2, d3, d4, d5, d6, led, edit_state};

    logic [6:0] segt [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    function automatic logic [50:0] mk(int y, int m, int dd, int w, int st);
        logic [5:0] l;
        l = (w == 0) ? 6'b111111 : (6'b100000 >> (w - 1));
        mk = {segt[y / 10], segt[y % 10], segt[m / 10], segt[m % 10],
              segt[dd / 10], segt[dd % 10], l, 3'(st)};
    endfunction

    function automatic logic [50:0] msk(int st);
        logic [50:0] m;
        m = '1;
        case (st)
            1: m[50:37] = '0;
            2: m[36:23] = '0;
            3: m[22:9]  = '0;
            4: m[8:3]   = '0;
            default: ;
        endcase
        msk = m;
    endfunction

    // Monitor: pops one expectation per falling edge while any are pending.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            it = q.pop_front();
            n_chk++;
            if (it.kind == 0) begin
                if ((obs & it.mask) == (it.exp & it.mask)) n_pass++;
                else $display("FAIL %s: actual %h required %h", it.name,
                              obs & it.mask, it.exp & it.mask);
            end else begin
                if (it.act == int'(it.exp)) n_pass++;
                else $display("FAIL %s: actual %0d required %0d", it.name, it.act, it.exp);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string nm, int y, int m, int dd, int w, int st);
        item_t e;
        tick(2);
        e.name = nm; e.kind = 0; e.exp = mk(y, m, dd, w, st); e.mask = msk(st); e.act = 0;
        q.push_back(e);
        tick(1);
    endtask

    task automatic press_set(int n);
        repeat (n) begin set = 1'b1; tick(1); set = 1'b0; tick(1); end
    endtask

    task automatic press_up(int n);
        repeat (n) begin up = 1'b1; tick(1); up = 1'b0; tick(1); end
    endtask

    task automatic press_dn(int n);
        repeat (n) begin down = 1'b1; tick(1); down = 1'b0; tick(1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        item_t e;
        int cnt;
        tick(3);
        reset = 1'b0;
        chk("reset", 0, 1, 1, 0, 0);

        day_tick = 1'b1; tick(365); day_tick = 1'b0;
        chk("tick365", 0, 12, 31, 1, 0);
        day_tick = 1'b1; tick(1); day_tick = 1'b0;
        chk("tick366", 1, 1, 1, 2, 0);

        press_set(1);
        chk("enter_year", 1, 1, 1, 2, 1);
        press_dn(2); press_set(1); press_dn(1); press_set(1); press_dn(1); press_set(2);
        chk("set_991231", 99, 12, 31, 2, 0);
        day_tick = 1'b1; tick(1); day_tick = 1'b0;
        chk("century_wrap", 0, 1, 1, 3, 0);

        press_set(1); press_up(1); press_set(1); press_up(2); press_set(1); press_dn(1); press_set(2);
        chk("set_010331", 1, 3, 31, 3, 0);
        press_set(2); press_dn(1); press_set(3);
        chk("clamp_feb28", 1, 2, 28, 3, 0);
        press_set(1); press_up(3); press_set(1); press_up(1); press_set(1); press_up(3); press_set(2);
        chk("set_040331", 4, 3, 31, 3, 0);
        press_set(2); press_dn(1); press_set(3);
        chk("clamp_feb29", 4, 2, 29, 3, 0);
        press_set(1); press_up(1); press_set(4);
        chk("year_clamp", 5, 2, 28, 3, 0);

        press_set(1); press_dn(7);
        up = 1'b1; tick(3 * R + 1); up = 1'b0; tick(1);
        up = 1'b1; down = 1'b1; tick(10); up = 1'b0; down = 1'b0; tick(3);
        cnt = 0;
        repeat (2 * B) begin
            @(negedge clk);
            if (d1 == 7'd0) cnt++;
        end
        #1;
        e.name = "blink"; e.kind = 1; e.exp = 51'(B); e.mask = '1; e.act = cnt;
        q.push_back(e);
        tick(1);
        chk("repeat_state", 2, 2, 28, 3, 1);
        press_set(4);
        chk("repeat_year02", 2, 2, 28, 3, 0);

        isUsing = 3'd2;
        press_set(1); press_up(1);
        chk("not_using", 2, 2, 28, 3, 0);
        isUsing = 3'd1;

        set = 1'b1; tick(10); set = 1'b0; tick(1);
        chk("set_held", 2, 2, 28, 3, 1);
        day_tick = 1'b1; tick(1); day_tick = 1'b0;
        press_set(1);
        chk("tick_in_edit", 2, 2, 28, 3, 2);

        reset = 1'b1; tick(1); reset = 1'b0;
        chk("reset_mid_edit", 0, 1, 1, 0, 0);

        day_tick = 1'b1; set = 1'b1; tick(1); day_tick = 1'b0; set = 1'b0;
        chk("tick_and_set", 0, 1, 2, 1, 1);

        tick(2);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: actual %0d pending required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
